// File: rtl/sdp_bram_scoreboard.sv
// Scoreboard for NCH simple-dual-port RAM channels. Keeps a byte-lane shadow
// of every channel with per-lane "written" bits, replays reads through an
// RDLAT-deep pipeline and compares only lanes that were ever written.
// Optional feature macro: SDP_COLLISION_CHECK_EN -- when defined, reads that
// collide with a same-edge write to the same address are not checked.
module sdp_bram_scoreboard #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned ABITS     = 10,
  parameter int unsigned DBITS     = 36,
  parameter int unsigned BYTEWIDTH = 9,
  parameter int unsigned RDLAT     = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NCH-1:0]                    we,
  input  logic [NCH-1:0]                    re,
  input  logic [NCH*ABITS-1:0]              wa,
  input  logic [NCH*ABITS-1:0]              ra,
  input  logic [NCH*DBITS-1:0]              wd,
  input  logic [NCH*(DBITS/BYTEWIDTH)-1:0]  be,
  input  logic [NCH*DBITS-1:0]              rd_dut,
  input  logic                              clr,
  output logic [NCH-1:0]                    chk_valid,
  output logic [NCH-1:0]                    mismatch,
  output logic                              err_sticky,
  output logic [15:0]                       err_count
);

  localparam int unsigned NBYTES = DBITS / BYTEWIDTH;
  localparam int unsigned DEPTH  = 1 << ABITS;

  // Shadow storage: data is never reset, the written bits are.
  logic [DBITS-1:0]  r_mem [NCH][DEPTH];
  logic [NBYTES-1:0] r_wr  [NCH][DEPTH];

  // Read replay pipeline, stage 0 captured on the re edge.
  logic [RDLAT-1:0]  r_pv [NCH];
  logic [DBITS-1:0]  r_pd [NCH][RDLAT];
  logic [NBYTES-1:0] r_pm [NCH][RDLAT];

  logic [NCH-1:0]    r_chk;
  logic [NCH-1:0]    r_mis;
  logic              r_sticky;
  logic [15:0]       r_cnt;

  logic [ABITS-1:0]  w_wa [NCH];
  logic [ABITS-1:0]  w_ra [NCH];
  logic [NCH-1:0]    w_cap;
  logic [NBYTES-1:0] w_lane_bad [NCH];
  logic [NCH-1:0]    w_chk_d;
  logic [NCH-1:0]    w_mis_d;
  logic [2:0]        w_inc;
  logic [15:0]       w_base;
  logic [16:0]       w_sum;
  logic [15:0]       w_cnt_d;
  logic              w_sticky_d;

  // Split the flat address buses and decide which reads get captured.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      w_wa[c]  = wa[c*ABITS +: ABITS];
      w_ra[c]  = ra[c*ABITS +: ABITS];
`ifdef SDP_COLLISION_CHECK_EN
      // A same-address write on the same edge makes the RAM output ambiguous.
      w_cap[c] = re[c] & ~(we[c] & (w_wa[c] == w_ra[c]));
`else
      w_cap[c] = re[c];
`endif
    end
  end

  // Shadow data write with byte enables.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (we[c]) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (be[c*NBYTES + i]) begin
            r_mem[c][w_wa[c]][i*BYTEWIDTH +: BYTEWIDTH] <=
                wd[c*DBITS + i*BYTEWIDTH +: BYTEWIDTH];
          end
        end
      end
    end
  end

  // Written-lane tracking, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
          r_wr[c][a] <= '0;
        end
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (we[c]) begin
          r_wr[c][w_wa[c]] <= r_wr[c][w_wa[c]] | be[c*NBYTES +: NBYTES];
        end
      end
    end
  end

  // Read pipeline payload; reads old contents so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      r_pd[c][0] <= r_mem[c][w_ra[c]];
      r_pm[c][0] <= r_wr[c][w_ra[c]];
      for (int unsigned s = 1; s < RDLAT; s++) begin
        r_pd[c][s] <= r_pd[c][s-1];
        r_pm[c][s] <= r_pm[c][s-1];
      end
    end
  end

  // Read pipeline valids; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_pv[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_pv[c][0] <= w_cap[c];
        for (int unsigned s = 1; s < RDLAT; s++) begin
          r_pv[c][s] <= r_pv[c][s-1];
        end
      end
    end
  end

  // Lane-wise compare of the final stage against the RAM output.
  always_comb begin
    w_chk_d = '0;
    w_mis_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_lane_bad[c] = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        w_lane_bad[c][i] = |(rd_dut[c*DBITS + i*BYTEWIDTH +: BYTEWIDTH] ^
                             r_pd[c][RDLAT-1][i*BYTEWIDTH +: BYTEWIDTH]);
      end
      w_chk_d[c] = r_pv[c][RDLAT-1] & (|r_pm[c][RDLAT-1]);
      w_mis_d[c] = w_chk_d[c] & (|(w_lane_bad[c] & r_pm[c][RDLAT-1]));
    end
  end

  // Error accounting: clear first, then add this cycle's mismatches, saturating.
  always_comb begin
    w_inc = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_inc = w_inc + {2'b00, w_mis_d[c]};
    end
    w_base     = clr ? 16'h0000 : r_cnt;
    w_sum      = {1'b0, w_base} + {14'h0000, w_inc};
    w_cnt_d    = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    w_sticky_d = (~clr & r_sticky) | (|w_mis_d);
  end

  // Registered compare strobes and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk    <= '0;
      r_mis    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_chk    <= w_chk_d;
      r_mis    <= w_mis_d;
      r_sticky <= w_sticky_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign chk_valid  = r_chk;
  assign mismatch   = r_mis;
  assign err_sticky = r_sticky;
  assign err_count  = r_cnt;

endmodule

// File: tb/tb_sdp_bram_scoreboard.sv
// Directed bench for sdp_bram_scoreboard, two channels, RDLAT=2.
// Honours SDP_COLLISION_CHECK_EN for the same-edge write/read case.
module tb_sdp_bram_scoreboard;

  localparam int NCH = 2;
  localparam int AB  = 10;
  localparam int DB  = 36;
  localparam int NB  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    we, re;
  logic [NCH*AB-1:0] wa, ra;
  logic [NCH*DB-1:0] wd, rd_dut;
  logic [NCH*NB-1:0] be;
  logic              clr;
  logic [NCH-1:0]    chk_valid, mismatch;
  logic              err_sticky;
  logic [15:0]       err_count;

  int n_total = 0;
  int n_bad   = 0;

  sdp_bram_scoreboard #(
    .NCH(NCH), .ABITS(AB), .DBITS(DB), .BYTEWIDTH(9), .RDLAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .wa(wa), .ra(ra), .wd(wd),
    .be(be), .rd_dut(rd_dut), .clr(clr), .chk_valid(chk_valid),
    .mismatch(mismatch), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [9:0] a, input logic [35:0] d,
                    input logic [3:0] bm);
    we[ch] = 1'b1;
    wa[ch*AB +: AB] = a;
    wd[ch*DB +: DB] = d;
    be[ch*NB +: NB] = bm;
    tick();
    we = '0;
  endtask

  // Issue a read (any pending write fires on the same edge), then check the
  // strobes two and three edges later for RDLAT=2.
  task automatic rd2(input string tag, input logic [1:0] rv, input logic [9:0] a0,
                     input logic [9:0] a1, input logic [35:0] d0, input logic [35:0] d1,
                     input logic [1:0] ev, input logic [1:0] em);
    re = rv;
    ra = {a1, a0};
    rd_dut = {d1, d0};
    tick();
    re = '0;
    we = '0;
    tick();
    check_eq({tag, "_early"}, {34'd0, chk_valid}, 36'd0);
    tick();
    check_eq({tag, "_valid"}, {34'd0, chk_valid}, {34'd0, ev});
    check_eq({tag, "_mis"}, {34'd0, mismatch}, {34'd0, em});
  endtask

  initial begin
    rst_n = 1'b0;
    we = '0; re = '0; wa = '0; ra = '0; wd = '0; be = '0; rd_dut = '0; clr = 1'b0;
    tick();
    tick();
    check_eq("rst_chk", {34'd0, chk_valid}, 36'd0);
    check_eq("rst_mis", {34'd0, mismatch}, 36'd0);
    check_eq("rst_sticky", {35'd0, err_sticky}, 36'd0);
    check_eq("rst_count", {20'd0, err_count}, 36'd0);
    rst_n = 1'b1;
    tick();

    // Full-word write and matching read.
    wr(0, 10'd5, 36'h123456789, 4'hF);
    rd2("basic", 2'b01, 10'd5, 10'd0, 36'h123456789, 36'h0, 2'b01, 2'b00);
    check_eq("basic_cnt", {20'd0, err_count}, 36'd0);

    // Single-bit error.
    rd2("err1", 2'b01, 10'd5, 10'd0, 36'h123456788, 36'h0, 2'b01, 2'b01);
    check_eq("err1_cnt", {20'd0, err_count}, 36'd1);
    check_eq("err1_sticky", {35'd0, err_sticky}, 36'd1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_cnt", {20'd0, err_count}, 36'd0);
    check_eq("clr_sticky", {35'd0, err_sticky}, 36'd0);

    // Partial write: only byte 0 is compared.
    wr(0, 10'd3, 36'h0000000AB, 4'b0001);
    rd2("part_ok", 2'b01, 10'd3, 10'd0, 36'hFFFFFF0AB, 36'h0, 2'b01, 2'b00);
    rd2("part_bad", 2'b01, 10'd3, 10'd0, 36'h0000000AC, 36'h0, 2'b01, 2'b01);
    check_eq("part_cnt", {20'd0, err_count}, 36'd1);

    // Never-written address is not compared.
    rd2("unwr", 2'b10, 10'd0, 10'd9, 36'h0, 36'hDEADBEEF, 2'b00, 2'b00);

    // Both channels wrong in the same cycle.
    wr(1, 10'd4, 36'h0F0F0F0F0, 4'hF);
    rd2("both", 2'b11, 10'd5, 10'd4, 36'h0, 36'h0F0F0F0F1, 2'b11, 2'b11);
    check_eq("both_cnt", {20'd0, err_count}, 36'd3);

    // Same-edge write and read of addr 7: read sees the old data.
    wr(0, 10'd7, 36'h55, 4'hF);
    we[0] = 1'b1;
    wa[0 +: AB] = 10'd7;
    wd[0 +: DB] = 36'hAA;
    be[0 +: NB] = 4'hF;
`ifdef SDP_COLLISION_CHECK_EN
    rd2("coll", 2'b01, 10'd7, 10'd0, 36'h55, 36'h0, 2'b00, 2'b00);
`else
    rd2("coll", 2'b01, 10'd7, 10'd0, 36'h55, 36'h0, 2'b01, 2'b00);
`endif
    rd2("coll_new", 2'b01, 10'd7, 10'd0, 36'hAA, 36'h0, 2'b01, 2'b00);
    check_eq("coll_cnt", {20'd0, err_count}, 36'd3);

    // clr in the same cycle as a mismatch: the mismatch wins.
    re = 2'b01;
    ra = {10'd0, 10'd5};
    rd_dut = {36'h0, 36'h0};
    tick();
    re = '0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clrmis_mis", {34'd0, mismatch}, 36'd1);
    check_eq("clrmis_cnt", {20'd0, err_count}, 36'd1);
    check_eq("clrmis_sticky", {35'd0, err_sticky}, 36'd1);

    // Saturation: 32767 back-to-back dual-channel errors reach 16'hFFFE.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    re = 2'b11;
    ra = {10'd4, 10'd5};
    rd_dut = '0;
    for (int i = 0; i < 32767; i++) tick();
    re = '0;
    tick();
    tick();
    tick();
    check_eq("pre_sat", {20'd0, err_count}, 36'hFFFE);
    re = 2'b11;
    tick();
    re = 2'b01;
    tick();
    re = '0;
    tick();
    tick();
    tick();
    check_eq("sat", {20'd0, err_count}, 36'hFFFF);
    check_eq("sat_sticky", {35'd0, err_sticky}, 36'd1);

    // Reset with two wrong reads in flight.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    re = 2'b01;
    ra = {10'd0, 10'd5};
    rd_dut = '0;
    tick();
    tick();
    re = '0;
    rst_n = 1'b0;
    #2;
    check_eq("inrst_chk", {34'd0, chk_valid}, 36'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("postrst_chk", {34'd0, chk_valid}, 36'd0);
    end
    check_eq("postrst_cnt", {20'd0, err_count}, 36'd0);
    check_eq("postrst_sticky", {35'd0, err_sticky}, 36'd0);
    rd2("wrclr0", 2'b01, 10'd5, 10'd0, 36'h0, 36'h0, 2'b00, 2'b00);
    rd2("wrclr1", 2'b11, 10'd7, 10'd4, 36'h1, 36'h1, 2'b00, 2'b00);
    check_eq("final_cnt", {20'd0, err_count}, 36'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sdp_bram_scoreboard.md
SDP_BRAM_SCOREBOARD -- requirements
Module: sdp_bram_scoreboard

Interface
- REQ-001 SHALL have parameter NCH, default 2: number of independent simple-dual-port channels, range 1..4.
- REQ-002 SHALL have parameter ABITS, default 10: address width per channel, range 1..10.
- REQ-003 SHALL have parameter DBITS, default 36: data width per channel.
- REQ-004 SHALL have parameter BYTEWIDTH, default 9: byte-lane width; DBITS SHALL be a multiple of it, and NBYTES = DBITS/BYTEWIDTH.
- REQ-005 SHALL have parameter RDLAT, default 1: read latency of the checked RAM, 1 or 2.
- REQ-006 SHALL have port clk, input, 1: sole clock; all channels sample on its rising edge.
- REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-008 SHALL have ports we, input, NCH (write enable) and re, input, NCH (read enable), each one bit per channel.
- REQ-009 SHALL have ports wa and ra, input, NCH*ABITS: write and read addresses, channel c at [c*ABITS+:ABITS].
- REQ-010 SHALL have ports wd, input, NCH*DBITS (write data) and be, input, NCH*NBYTES (byte enables).
- REQ-011 SHALL have port rd_dut, input, NCH*DBITS: read data from the RAM under test.
- REQ-012 SHALL have port clr, input, 1: synchronous clear of error state.
- REQ-013 SHALL have ports chk_valid and mismatch, output, NCH each: per-channel compare-performed and compare-failed strobes.
- REQ-014 SHALL have port err_sticky, output, 1, and port err_count, output, 16: error flag and error count.

Function
- REQ-015 SHALL keep per channel a shadow memory of 2^ABITS x DBITS plus one written bit per byte lane per address.
- REQ-016 SHALL, on a rising edge with we[c]=1, write byte i of wd into shadow[c][wa] and set its written bit for every i with be[c][i]=1; other bytes stay unchanged.
- REQ-017 SHALL, on a rising edge with re[c]=1, capture the expected data and the written mask of shadow[c][ra] as they were before that edge's write (read-first).
- REQ-018 SHALL pipeline the captured read RDLAT stages and compare it against rd_dut[c] one cycle after the final stage, counted from the re edge.
- REQ-019 SHALL compare only byte lanes whose captured written bit is 1; chk_valid[c]=1 for one cycle when at least one lane is compared.
- REQ-020 SHALL drive mismatch[c]=1 in the same cycle as chk_valid[c] when any compared lane differs; otherwise 0.
- REQ-021 SHALL set err_sticky and increment err_count by the number of channels mismatching in that cycle, saturating at 16'hFFFF.
- REQ-022 SHALL let clr=1 zero err_count and err_sticky on the next edge; a mismatch in the same cycle wins, leaving err_sticky=1 and err_count equal to that cycle's increment.
- REQ-023 SHALL treat back-to-back reads on one channel as fully pipelined, with one compare per read and no stalls.

Reset
- REQ-024 SHALL, while rst_n=0, asynchronously clear all written bits, pipeline valids, chk_valid, mismatch, err_sticky and err_count to 0; shadow data is not reset.
- REQ-025 SHALL discard reads in flight when reset asserts mid-operation; no compare fires for them after release.

Configuration
- REQ-026 SHALL honour macro SDP_COLLISION_CHECK_EN.
- REQ-027 SHALL, when SDP_COLLISION_CHECK_EN is defined, suppress the compare of any read captured with we[c]&re[c]&(wa==ra) on that channel; its chk_valid stays 0.
- REQ-028 SHALL, when SDP_COLLISION_CHECK_EN is undefined, compare colliding reads against the read-first (old) data.

Verification
- REQ-029 SHALL cover: ch0 write wd=36'h123456789, be=4'hF, addr 5, then read addr 5 with rd_dut matching -> chk_valid[0]=1 at re+RDLAT+1, mismatch 0, err_count 0.
- REQ-030 SHALL cover: write be=4'b0001 to addr 3, then read with rd_dut upper bytes garbage and byte 0 correct -> no mismatch.
- REQ-031 SHALL cover: both channels read with wrong data in the same cycle -> mismatch=2'b11 and err_count +2.
- REQ-032 SHALL cover: same-edge write 'hAA over old 'h55 and read of addr 7 -> expected 'h55 when SDP_COLLISION_CHECK_EN is undefined; no chk_valid when it is defined.
- REQ-033 SHALL cover: err_count preloaded to 16'hFFFE by forced mismatches, then 3 more mismatches -> err_count holds 16'hFFFF.
- REQ-034 SHALL cover: rst_n pulsed low with two reads in flight, RDLAT=2 -> no chk_valid after release and every written bit cleared.
